// File: rtl/adxl362_spi_sequencer.sv
// Wishbone master that drives a simple_spi core to configure an ADXL362 and
// burst-read X/Y/Z, either on request or from a free-running sample timer.
module adxl362_spi_sequencer #(
  parameter logic [7:0]  SPCR_VAL   = 8'h50,
  parameter logic [7:0]  SPER_VAL   = 8'h00,
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned CS_GUARD   = 4,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        start_i,
  output logic [1:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        ncs_o,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic [15:0] z_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        init_done_o,
  output logic        err_o
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;
  localparam logic [1:0] ADR_SPER = 2'd3;

  typedef enum logic [3:0] {
    INIT_SPCR, INIT_SPER, INIT_CS, SAMPLE_CS, BYTE_WR, POLL, BYTE_RD,
    CS_HOLD, DONE, IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [1:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic          ncs_q, ncs_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [2:0]    byte_q, byte_d;
  logic          init_mode_q, init_mode_d;
  logic [47:0]   rx_q, rx_d;
  logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;

  logic [7:0] tx_byte;
  logic       last_byte;
  logic       guard_done;
  logic       poll_hit;
  logic       tick;

  // Init transfer writes POWER_CTL=measure; sample transfer is a burst read from XDATA_L.
  always_comb begin
    tx_byte = 8'h00;
    if (init_mode_q) begin
      case (byte_q)
        3'd0:    tx_byte = 8'h0A;
        3'd1:    tx_byte = 8'h2D;
        default: tx_byte = 8'h02;
      endcase
    end else begin
      case (byte_q)
        3'd0:    tx_byte = 8'h0B;
        3'd1:    tx_byte = 8'h0E;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign last_byte  = init_mode_q ? (byte_q == 3'd2) : (byte_q == 3'd7);
  assign guard_done = (32'(guard_q) + 32'd1 >= CS_GUARD);
  assign poll_hit   = (32'(poll_q) + 32'd1 >= POLL_LIMIT);
  assign tick       = enable_i && init_done_q && (SAMPLE_DIV != 0) &&
                      (32'(timer_q) == SAMPLE_DIV - 1);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    ncs_d       = ncs_q;
    guard_d     = guard_q;
    poll_d      = poll_q;
    byte_d      = byte_q;
    init_mode_d = init_mode_q;
    rx_d        = rx_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q;
    timer_d     = timer_q;
    pend_d      = pend_q;

    if (!enable_i) begin
      timer_d = '0;
      pend_d  = 1'b0;
    end else if (init_done_q && (SAMPLE_DIV != 0)) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
      if (tick) pend_d = 1'b1;
    end

    // Every access state: raise cyc when idle, hold everything until ack, then drop.
    case (state_q)
      INIT_SPCR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPCR; dat_d = SPCR_VAL;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0; we_d = 1'b0; state_d = INIT_SPER;
        end
      end
      INIT_SPER: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPER; dat_d = SPER_VAL;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0; we_d = 1'b0; ncs_d = 1'b0; guard_d = '0;
          byte_d = '0; init_mode_d = 1'b1; state_d = INIT_CS;
        end
      end
      INIT_CS, SAMPLE_CS: begin
        if (guard_done) begin
          guard_d = '0; state_d = BYTE_WR;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      BYTE_WR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPDR; dat_d = tx_byte;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0; we_d = 1'b0; poll_d = '0; state_d = POLL;
        end
      end
      POLL: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SPSR;
        end else if (wb_ack_i) begin
          cyc_d  = 1'b0;
          poll_d = poll_q + PW'(1);
          if (!wb_dat_i[0]) begin
            state_d = BYTE_RD;
          end else if (poll_hit) begin
            err_d   = 1'b1;
            ncs_d   = 1'b1;
            state_d = init_mode_q ? INIT_SPCR : IDLE;
          end
        end
      end
      BYTE_RD: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SPDR;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          // Data bytes shift in from the top so rx_q ends as {ZH,ZL,YH,YL,XH,XL}.
          if (!init_mode_q && (byte_q >= 3'd2)) rx_d = {wb_dat_i, rx_q[47:8]};
          if (last_byte) begin
            guard_d = '0; state_d = CS_HOLD;
          end else begin
            byte_d = byte_q + 3'd1; state_d = BYTE_WR;
          end
        end
      end
      CS_HOLD: begin
        if (guard_done) begin
          guard_d = '0;
          ncs_d   = 1'b1;
          if (init_mode_q) begin
            init_done_d = 1'b1; init_mode_d = 1'b0; state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      DONE: begin
        x_d     = rx_q[15:0];
        y_d     = rx_q[31:16];
        z_d     = rx_q[47:32];
        valid_d = 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      IDLE: begin
        // Entry clears pending after the timer update, so a tick coinciding with start_i yields one sample.
        if (enable_i && (start_i || pend_q)) begin
          ncs_d = 1'b0; guard_d = '0; byte_d = '0; init_mode_d = 1'b0;
          pend_d = 1'b0; state_d = SAMPLE_CS;
        end
      end
      default: state_d = INIT_SPCR;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= INIT_SPCR;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      ncs_q       <= 1'b1;
      guard_q     <= '0;
      poll_q      <= '0;
      byte_q      <= '0;
      init_mode_q <= 1'b0;
      rx_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      ncs_q       <= ncs_d;
      guard_q     <= guard_d;
      poll_q      <= poll_d;
      byte_q      <= byte_d;
      init_mode_q <= init_mode_d;
      rx_q        <= rx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign ncs_o       = ncs_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign z_o         = z_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_adxl362_spi_sequencer.sv
// Bench for adxl362_spi_sequencer: simple_spi + ADXL362 behavioural model,
// MOSI-byte and sample scoreboards, one line printed per completed sample.
module tb_adxl362_spi_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        ncs_o;
  logic [15:0] x_o, y_o, z_o;
  logic        valid_o, busy_o, init_done_o, err_o;

  always #5 clk = ~clk;

  adxl362_spi_sequencer #(
    .SPCR_VAL(8'h50), .SPER_VAL(8'h00), .SAMPLE_DIV(2000),
    .CS_GUARD(4), .POLL_LIMIT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .start_i(start),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .ncs_o(ncs_o), .x_o(x_o), .y_o(y_o), .z_o(z_o),
    .valid_o(valid_o), .busy_o(busy_o), .init_done_o(init_done_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboards
  logic [7:0]  mosi_q[$];
  logic [47:0] sb_q[$];
  int          vt[$];
  int          cyc_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  // Slave model state
  int         ack_dly = 1;
  int         wait_n = 0;
  bit         stuck = 0;
  int         tx_idx = 0;
  int         busy_cnt = 0;
  int         spsr_reads = 0;
  int         spcr_wr = 0;
  int         sper_wr = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [15:0] mx = 16'h0, my = 16'h0, mz = 16'h0;
  logic [1:0] a_adr;
  logic [7:0] a_dat;
  logic       a_we;
  bit         a_moved;
  logic [31:0] exp_b;

  function automatic logic [7:0] resp(input int idx);
    case (idx)
      2: return mx[7:0];
      3: return mx[15:8];
      4: return my[7:0];
      5: return my[15:8];
      6: return mz[7:0];
      7: return mz[15:8];
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wait_n == 0) begin
        a_adr = wb_adr_o; a_dat = wb_dat_o; a_we = wb_we_o; a_moved = 0;
      end else if ({wb_adr_o, wb_dat_o, wb_we_o} !== {a_adr, a_dat, a_we}) begin
        a_moved = 1;
      end
      wait_n++;
      if (wait_n >= ack_dly) begin
        check_eq("wb_stable", 32'(a_moved), 32'd0);
        if (a_we) begin
          case (a_adr)
            2'd0: begin spcr_wr++; check_eq("spcr_val", 32'(a_dat), 32'h50); end
            2'd3: begin sper_wr++; check_eq("sper_val", 32'(a_dat), 32'h00); end
            2'd2: begin
              exp_b = (mosi_q.size() != 0) ? 32'(mosi_q.pop_front()) : 32'h100;
              check_eq("mosi", 32'(a_dat), exp_b);
              check_eq("ncs_low_tx", 32'(ncs_o), 32'd0);
              rx_byte = resp(tx_idx);
              tx_idx++;
              busy_cnt = 2;
            end
            default: ;
          endcase
        end else begin
          case (a_adr)
            2'd1: begin
              spsr_reads++;
              wb_dat_i = {7'd0, stuck || (busy_cnt != 0)};
              if (busy_cnt != 0) busy_cnt--;
            end
            2'd2: wb_dat_i = rx_byte;
            default: wb_dat_i = 8'h00;
          endcase
        end
        wb_ack_i = 1'b1;
        wait_n = 0;
      end
    end else begin
      wait_n = 0;
    end
    if (ncs_o) tx_idx = 0;
  end

  // Output monitors
  logic        valid_prev = 1'b0;
  logic        ncs_prev = 1'b1;
  logic [47:0] exp_s;
  bit          have_s;

  always @(negedge clk) begin
    if (valid_prev) check_eq("valid_1cyc", 32'(valid_o), 32'd0);
    if (valid_o) begin
      vt.push_back(cyc_cnt);
      have_s = (sb_q.size() != 0);
      exp_s  = have_s ? sb_q.pop_front() : 48'h0;
      check_eq("x", 32'(x_o), have_s ? 32'(exp_s[47:32]) : 32'h1_0000);
      check_eq("y", 32'(y_o), have_s ? 32'(exp_s[31:16]) : 32'h1_0000);
      check_eq("z", 32'(z_o), have_s ? 32'(exp_s[15:0])  : 32'h1_0000);
      $display("sample @%0d x=%h y=%h z=%h", cyc_cnt, x_o, y_o, z_o);
    end
    valid_prev = valid_o;
    if (rst_n && (ncs_o !== ncs_prev)) check_eq("ncs_vs_cyc", 32'(wb_cyc_o), 32'd0);
    ncs_prev = ncs_o;
  end

  task automatic push_init();
    mosi_q.push_back(8'h0A); mosi_q.push_back(8'h2D); mosi_q.push_back(8'h02);
  endtask

  task automatic push_sample();
    mosi_q.push_back(8'h0B); mosi_q.push_back(8'h0E);
    for (int i = 0; i < 6; i++) mosi_q.push_back(8'h00);
    sb_q.push_back({mx, my, mz});
  endtask

  task automatic wait_init(input string tag);
    for (int n = 0; n < 3000 && !init_done_o; n++) @(negedge clk);
    check_eq({tag, "_init_done"}, 32'(init_done_o), 32'd1);
  endtask

  task automatic run_sample(input string tag);
    @(negedge clk);
    enable = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3000 && busy_o; n++) @(negedge clk);
    check_eq({tag, "_idle"}, 32'(busy_o), 32'd0);
    enable = 1'b0;
    @(negedge clk);
  endtask

  int base, sr0, spcr0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(wb_stb_o), 32'd0);
    check_eq("rst_we",  32'(wb_we_o),  32'd0);
    check_eq("rst_adr", 32'(wb_adr_o), 32'd0);
    check_eq("rst_dat", 32'(wb_dat_o), 32'd0);
    check_eq("rst_ncs", 32'(ncs_o), 32'd1);
    check_eq("rst_xyz", 32'({x_o, y_o} | 32'(z_o)), 32'd0);
    check_eq("rst_flags", 32'({valid_o, busy_o, init_done_o, err_o}), 32'd0);

    // Init sequence
    push_init();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("init_busy", 32'(busy_o), 32'd1);
    wait_init("init");
    check_eq("init_spcr_cnt", 32'(spcr_wr), 32'd1);
    check_eq("init_sper_cnt", 32'(sper_wr), 32'd1);
    check_eq("init_ncs", 32'(ncs_o), 32'd1);
    check_eq("init_no_valid", 32'(vt.size()), 32'd0);
    check_eq("init_mosi_left", 32'(mosi_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("init_idle", 32'(busy_o), 32'd0);

    // Single sample
    mx = 16'h0123; my = 16'hFF85; mz = 16'h0400;
    base = vt.size();
    push_sample();
    run_sample("single");
    check_eq("single_pulses", 32'(vt.size() - base), 32'd1);
    check_eq("single_ncs", 32'(ncs_o), 32'd1);
    check_eq("single_x_hold", 32'(x_o), 32'h0123);

    // Second pattern, sign extremes
    mx = 16'h7FFF; my = 16'h8000; mz = 16'hFFFF;
    push_sample();
    run_sample("extreme");

    // Slow ack
    ack_dly = 5;
    mx = 16'h0123; my = 16'hFF85; mz = 16'h0400;
    base = vt.size();
    push_sample();
    run_sample("slow");
    check_eq("slow_pulses", 32'(vt.size() - base), 32'd1);
    ack_dly = 1;

    // Poll timeout
    stuck = 1;
    sr0 = spsr_reads;
    base = vt.size();
    mosi_q.push_back(8'h0B);
    run_sample("tmo");
    check_eq("tmo_polls", 32'(spsr_reads - sr0), 32'd16);
    check_eq("tmo_err", 32'(err_o), 32'd1);
    check_eq("tmo_ncs", 32'(ncs_o), 32'd1);
    check_eq("tmo_busy", 32'(busy_o), 32'd0);
    check_eq("tmo_no_valid", 32'(vt.size() - base), 32'd0);
    stuck = 0;
    mx = 16'h1357; my = 16'h2468; mz = 16'hFEDC;
    push_sample();
    run_sample("recover");
    check_eq("recover_err", 32'(err_o), 32'd0);

    // Periodic sampling
    mx = 16'h8001; my = 16'h00FF; mz = 16'h1234;
    for (int i = 0; i < 5; i++) push_sample();
    base = vt.size();
    @(negedge clk);
    enable = 1'b1;
    begin
      bit poked = 0;
      for (int i = 0; i < 10300; i++) begin
        @(negedge clk);
        if (!poked && busy_o) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          i++;
          poked = 1;
        end
      end
    end
    enable = 1'b0;
    for (int n = 0; n < 3000 && busy_o; n++) @(negedge clk);
    check_eq("per_idle", 32'(busy_o), 32'd0);
    @(negedge clk);
    check_eq("per_pulses", 32'(vt.size() - base), 32'd5);
    for (int k = 1; k < 5; k++)
      if (base + k < vt.size())
        check_eq("per_space", 32'(vt[base+k] - vt[base+k-1]), 32'd2000);
    check_eq("per_mosi_left", 32'(mosi_q.size()), 32'd0);

    // Reset during the 4th byte poll
    mx = 16'h4242; my = 16'h1111; mz = 16'h2222;
    push_sample();
    @(negedge clk);
    enable = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2000 && !(tx_idx == 4 && wb_cyc_o && !wb_we_o && wb_adr_o == 2'd1); n++)
      @(negedge clk);
    check_eq("rstmid_reach", 32'(tx_idx), 32'd4);
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_eq("rstmid_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rstmid_ncs", 32'(ncs_o), 32'd1);
    check_eq("rstmid_xyz", 32'({x_o, y_o} | 32'(z_o)), 32'd0);
    check_eq("rstmid_flags", 32'({busy_o, init_done_o}), 32'd0);
    mosi_q.delete();
    sb_q.delete();
    push_init();
    spcr0 = spcr_wr;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");
    check_eq("reinit_spcr_cnt", 32'(spcr_wr - spcr0), 32'd1);
    repeat (3) @(negedge clk);

    check_eq("mosi_left", 32'(mosi_q.size()), 32'd0);
    check_eq("sb_left", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
